// File: rtl/seg7_readback.sv
// Seven-segment readback decoder: watches the scanner's anode/segment buses, waits for
// each select/segment pair to settle, and rebuilds the BCD image plus error status.
module seg7_readback #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic [NUM_DIG-1:0]     i_dig_sel,
    input  logic [7:0]             i_seg_in,
    output logic [4*NUM_DIG-1:0]   o_digits_out,
    output logic [NUM_DIG-1:0]     o_dp_out,
    output logic [NUM_DIG-1:0]     o_dig_valid,
    output logic [NUM_DIG-1:0]     o_dig_err,
    output logic [7:0]             o_err_cnt,
    output logic                   o_frame_done
);

    localparam logic [1:0]         ST_IDLE  = 2'd0;
    localparam logic [1:0]         ST_TRACK = 2'd1;
    localparam logic [1:0]         ST_HELD  = 2'd2;
    localparam logic [7:0]         CNT_MAX  = 8'(STABLE_CYC);
    localparam logic [NUM_DIG-1:0] ALL_SEEN = '1;

    logic [1:0]           r_state;
    logic [7:0]           r_cnt;
    logic [NUM_DIG-1:0]   r_prev_sel;
    logic [7:0]           r_prev_seg;
    logic                 r_prev_legal;
    logic [4*NUM_DIG-1:0] r_digits;
    logic [NUM_DIG-1:0]   r_dp;
    logic [NUM_DIG-1:0]   r_valid;
    logic [NUM_DIG-1:0]   r_err;
    logic [7:0]           r_err_cnt;
    logic [NUM_DIG-1:0]   r_seen;
    logic                 r_frame;

    logic [3:0]           w_low_cnt;
    logic                 w_legal;
    logic                 w_same;
    logic [NUM_DIG-1:0]   w_sel_mask;
    logic                 w_dec_ok;
    logic [3:0]           w_dec_val;
    logic [1:0]           w_state_nxt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_commit;
    logic                 w_do_commit;
    logic [NUM_DIG-1:0]   w_seen_nxt;

    // A select is legal only with exactly one anode driven low.
    always_comb begin
        w_low_cnt = 4'd0;
        for (int i = 0; i < NUM_DIG; i++) begin
            w_low_cnt = w_low_cnt + {3'b000, ~i_dig_sel[i]};
        end
    end

    assign w_legal    = (w_low_cnt == 4'd1);
    assign w_sel_mask = ~i_dig_sel;
    assign w_same     = r_prev_legal && (i_dig_sel == r_prev_sel) && (i_seg_in == r_prev_seg);

    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_val = 4'd0;
        case (i_seg_in[7:1])
            7'b0000001: w_dec_val = 4'd0;
            7'b1001111: w_dec_val = 4'd1;
            7'b0010010: w_dec_val = 4'd2;
            7'b0000110: w_dec_val = 4'd3;
            7'b1001100: w_dec_val = 4'd4;
            7'b0100100: w_dec_val = 4'd5;
            7'b0100000: w_dec_val = 4'd6;
            7'b0001101: w_dec_val = 4'd7;
            7'b0000000: w_dec_val = 4'd8;
            7'b0000100: w_dec_val = 4'd9;
            default:    w_dec_ok  = 1'b0;
        endcase
    end

    // Commit fires only on the TRACK->HELD transition, so a long hold commits once.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        if (!w_legal) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
        end else if (!w_same) begin
            w_state_nxt = ST_TRACK;
            w_cnt_nxt   = 8'd1;
        end else begin
            if (r_cnt != CNT_MAX) begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
            if ((r_state == ST_TRACK) && (w_cnt_nxt == CNT_MAX)) begin
                w_commit    = 1'b1;
                w_state_nxt = ST_HELD;
            end
        end
    end

    assign w_do_commit = w_commit && !i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_prev_sel   <= '1;
            r_prev_seg   <= '1;
            r_prev_legal <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev_sel   <= i_dig_sel;
            r_prev_seg   <= i_seg_in;
            r_prev_legal <= w_legal;
        end
    end

    // The digit image survives CLR; only the status view is wiped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digits  <= '0;
            r_dp      <= '1;
            r_valid   <= '0;
            r_err     <= '0;
            r_err_cnt <= 8'd0;
        end else if (i_clr) begin
            r_valid   <= '0;
            r_err     <= '0;
            r_err_cnt <= 8'd0;
        end else if (w_do_commit) begin
            for (int k = 0; k < NUM_DIG; k++) begin
                if (w_sel_mask[k]) begin
                    if (w_dec_ok) begin
                        r_digits[4*k +: 4] <= w_dec_val;
                        r_dp[k]            <= i_seg_in[0];
                        r_valid[k]         <= 1'b1;
                    end else begin
                        r_err[k] <= 1'b1;
                    end
                end
            end
            if (!w_dec_ok && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // A full seen-mask produces the frame pulse and empties itself on the same edge.
    always_comb begin
        w_seen_nxt = (i_clr || (r_seen == ALL_SEEN)) ? '0 : r_seen;
        if (w_do_commit) begin
            w_seen_nxt = w_seen_nxt | w_sel_mask;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seen  <= '0;
            r_frame <= 1'b0;
        end else begin
            r_seen  <= w_seen_nxt;
            r_frame <= (r_seen == ALL_SEEN) && !i_clr;
        end
    end

    assign o_digits_out = r_digits;
    assign o_dp_out     = r_dp;
    assign o_dig_valid  = r_valid;
    assign o_dig_err    = r_err;
    assign o_err_cnt    = r_err_cnt;
    assign o_frame_done = r_frame;

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: directed steps plus random pairs, compared
// every cycle against a run-length reference model built from the decode table.
module tb_seg7_readback;

    localparam int NUM_DIG = 4;
    localparam int STABLE  = 4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [15:0] digitsOut;
    logic [3:0]  dpOut;
    logic [3:0]  digValid;
    logic [3:0]  digErr;
    logic [7:0]  errCnt;
    logic        frameDone;

    int errors = 0;
    int checks = 0;
    int framesSeen = 0;

    logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100};

    logic [15:0] mDigits;
    logic [3:0]  mDp, mValid, mErr, mSeen;
    int          mErrCnt;
    logic        mFrame;
    int          mRun;
    logic [3:0]  mPrevSel;
    logic [7:0]  mPrevSeg;
    logic        mPrevOk;

    seg7_readback #(.NUM_DIG(NUM_DIG), .STABLE_CYC(STABLE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_dig_sel(sel), .i_seg_in(seg),
        .o_digits_out(digitsOut), .o_dp_out(dpOut), .o_dig_valid(digValid),
        .o_dig_err(digErr), .o_err_cnt(errCnt), .o_frame_done(frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (PAT[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mDigits = '0; mDp = '1; mValid = '0; mErr = '0; mSeen = '0;
        mErrCnt = 0; mFrame = 1'b0; mRun = 0;
        mPrevSel = '1; mPrevSeg = '1; mPrevOk = 1'b0;
    endtask

    // Reference: a pair commits when it has been seen on exactly STABLE consecutive edges.
    task automatic modelEdge();
        bit legal, commit, newFrame;
        int k, d;
        legal  = ($countones(~sel) == 1);
        commit = 1'b0;
        if (!legal) mRun = 0;
        else if (!(mPrevOk && sel == mPrevSel && seg == mPrevSeg)) mRun = 1;
        else if (mRun < STABLE) begin
            mRun++;
            commit = (mRun == STABLE);
        end
        newFrame = (mSeen == 4'hF) && !clr;
        if (mSeen == 4'hF || clr) mSeen = '0;
        if (clr) begin
            mValid = '0; mErr = '0; mErrCnt = 0;
        end else if (commit) begin
            k = 0;
            for (int i = 0; i < NUM_DIG; i++) if (!sel[i]) k = i;
            d = decode(seg[7:1]);
            if (d >= 0) begin
                mDigits[4*k +: 4] = 4'(d);
                mDp[k] = seg[0];
                mValid[k] = 1'b1;
            end else begin
                mErr[k] = 1'b1;
                if (mErrCnt < 255) mErrCnt++;
            end
            mSeen[k] = 1'b1;
        end
        mFrame = newFrame;
        mPrevSel = sel; mPrevSeg = seg; mPrevOk = legal;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("digits", 32'(digitsOut), 32'(mDigits));
        chk("dp", 32'(dpOut), 32'(mDp));
        chk("valid", 32'(digValid), 32'(mValid));
        chk("err", 32'(digErr), 32'(mErr));
        chk("errcnt", 32'(errCnt), 32'(mErrCnt));
        chk("frame", 32'(frameDone), 32'(mFrame));
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic [7:0] g, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            sel = s; seg = g; clr = c;
            @(posedge clk);
            modelEdge();
            #1;
            if (frameDone === 1'b1) framesSeen++;
            checkOutput();
        end
    endtask

    initial begin
        logic [3:0] rs;
        logic [7:0] rg;
        int hold;

        rst_n = 1'b0; clr = 1'b0; sel = '1; seg = '1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        rst_n = 1'b1;

        $display("[TB] scan digits 0..3 with 1,2,3,4");
        framesSeen = 0;
        for (int d = 0; d < 4; d++) applyStimulus(~(4'b0001 << d), {PAT[d+1], 1'b1}, 1'b0, 4);
        applyStimulus(4'b1111, 8'hFF, 1'b0, 3);
        chk("scan_digits", 32'(digitsOut), 32'h4321);
        chk("scan_valid", 32'(digValid), 32'hF);
        chk("scan_frames", 32'(framesSeen), 32'd1);

        $display("[TB] short hold then full hold on digit 2");
        applyStimulus(4'b1011, {PAT[9], 1'b0}, 1'b0, 3);
        applyStimulus(4'b1110, {PAT[1], 1'b1}, 1'b0, 2);
        chk("short_hold", 32'(digitsOut[11:8]), 32'd3);
        applyStimulus(4'b1011, {PAT[9], 1'b0}, 1'b0, 4);
        chk("d2_value", 32'(digitsOut[11:8]), 32'd9);
        chk("d2_dp", 32'(dpOut[2]), 32'd0);

        $display("[TB] blank pattern on digit 1 for 10 cycles");
        applyStimulus(4'b1101, 8'hFF, 1'b0, 10);
        chk("d1_err", 32'(digErr[1]), 32'd1);
        chk("d1_errcnt", 32'(errCnt), 32'd1);
        chk("d1_kept", 32'(digitsOut[7:4]), 32'd2);

        $display("[TB] illegal selects");
        applyStimulus(4'b1010, {PAT[5], 1'b1}, 1'b0, 20);
        applyStimulus(4'b1111, {PAT[5], 1'b1}, 1'b0, 20);
        applyStimulus(4'b1110, {PAT[7], 1'b1}, 1'b0, 3);
        chk("fresh_count", 32'(digitsOut[3:0]), 32'd1);
        applyStimulus(4'b1110, {PAT[7], 1'b1}, 1'b0, 1);
        chk("fresh_commit", 32'(digitsOut[3:0]), 32'd7);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(4'b0111, 8'hFE, 1'b0, 4);
            applyStimulus(4'b1110, 8'hFE, 1'b0, 4);
        end
        chk("errcnt_sat", 32'(errCnt), 32'd255);
        applyStimulus(4'b1111, 8'hFF, 1'b1, 1);
        chk("clr_errcnt", 32'(errCnt), 32'd0);
        chk("clr_err", 32'(digErr), 32'd0);
        chk("clr_valid", 32'(digValid), 32'd0);
        chk("clr_keep", 32'(digitsOut), 32'h4927);

        $display("[TB] CLR coincident with commit");
        applyStimulus(4'b1101, {PAT[6], 1'b1}, 1'b0, 3);
        applyStimulus(4'b1101, {PAT[6], 1'b1}, 1'b1, 1);
        applyStimulus(4'b1101, {PAT[6], 1'b1}, 1'b0, 6);
        chk("clr_commit_digit", 32'(digitsOut[7:4]), 32'd2);
        chk("clr_commit_valid", 32'(digValid[1]), 32'd0);

        $display("[TB] random pairs");
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                8:       rs = 4'b1111;
                9:       rs = 4'($urandom_range(0, 15));
                default: rs = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 3) != 0) rg = {PAT[$urandom_range(0, 9)], 1'($urandom_range(0, 1))};
            else rg = 8'($urandom);
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) applyStimulus(rs, rg, 1'($urandom_range(0, 19) == 0), 1);
        end

        $display("[TB] async reset mid-hold");
        applyStimulus(4'b1110, {PAT[8], 1'b1}, 1'b0, 2);
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b1110, {PAT[8], 1'b1}, 1'b0, 3);
        chk("post_reset_wait", 32'(digitsOut[3:0]), 32'd0);
        applyStimulus(4'b1110, {PAT[8], 1'b1}, 1'b0, 1);
        chk("post_reset_commit", 32'(digitsOut[3:0]), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Seven-segment readback decoder: the inverse of the display path's BCD-to-segment decoder. It observes the multiplexed anode-select and segment buses driven by the display scanner, waits for each digit slot to be stable, decodes the segment pattern back to a BCD value, and maintains a per-digit register image plus error status. It sits beside the scanner in the traffic controller as a self-check and observability block. Its outputs feed the on-board debug readout and the verification bench.

## Interface
Parameters:
- NUM_DIG, 4: number of multiplexed digits, 2..8.
- STABLE_CYC, 4: number of consecutive sampling edges a select/segment pair must be held before it is committed, 2..255.

Ports:
- CLK  in  1  system clock. The scanner outputs are synchronous to this clock.
- RST_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear of status outputs; active-high.
- DIG_SEL  in  NUM_DIG  anode select, active-low; exactly one bit low is legal.
- SEG_IN  in  8  segment bus, active-low. Bits [7:1] = a..g, bit 0 = dp.
- DIGITS_OUT  out  4*NUM_DIG  decoded BCD image; digit k occupies [4k+3:4k].
- DP_OUT  out  NUM_DIG  last committed dp bit per digit, active-low as received.
- DIG_VALID  out  NUM_DIG  digit k holds a valid decoded value since reset/CLR.
- DIG_ERR  out  NUM_DIG  sticky: digit k saw an undecodable pattern.
- ERR_CNT  out  8  saturating count of undecodable commits.
- FRAME_DONE  out  1  one-cycle pulse when every digit has committed since the last pulse.

## Operation
- Decode table on SEG_IN[7:1]. dp is ignored for matching.
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001101, 8 = 0000000, 9 = 0000100
  - Any other pattern is invalid.
- Legal select: DIG_SEL has exactly one bit low. All-high, or two or more bits low, is illegal.
- State machine:
  - IDLE: select illegal; run counter = 0.
  - TRACK: counting stability of the current {DIG_SEL, SEG_IN} pair.
  - HELD: the pair has been committed; no further commit until the pair changes.
- Run counter rules (evaluated each edge against the previous sample):
  - Legal and identical to the previous sample: counter increments, saturating at STABLE_CYC.
  - Legal but different from the previous sample: counter = 1, go to TRACK.
  - Illegal: counter = 0, go to IDLE. This applies from any state.
- Commit: occurs on the edge at which the counter first reaches STABLE_CYC (TRACK to HELD). For selected digit k:
  - Valid pattern: DIGITS_OUT[k] = decoded value, DP_OUT[k] = SEG_IN[0], DIG_VALID[k] = 1.
  - Invalid pattern: DIGITS_OUT[k] and DIG_VALID[k] are unchanged; DIG_ERR[k] = 1; ERR_CNT increments, saturating at 255.
  - In both cases the seen-mask bit k is set.
- Frame: when a commit completes the seen-mask (all NUM_DIG bits set), FRAME_DONE pulses on the next edge and the mask clears on that same edge. Re-committing a digit already marked in the mask has no frame effect.
- CLR (synchronous): clears DIG_VALID, DIG_ERR, ERR_CNT and the seen-mask.
  - DIGITS_OUT and DP_OUT hold their values; FRAME_DONE is forced to 0.
  - The run counter and state machine are not affected by CLR.
  - If a commit coincides with CLR, the commit is discarded entirely, and the pair stays HELD, so it does not re-commit.

## Timing
- Reset values: DIGITS_OUT = 0, DP_OUT = all 1, DIG_VALID = 0, DIG_ERR = 0, ERR_CNT = 0, FRAME_DONE = 0, seen-mask = 0, state IDLE, counter = 0, previous sample = illegal.
- Commit latency: the first edge sampling a new pair is edge 0. Outputs show the commit after edge STABLE_CYC-1. A pair held for only STABLE_CYC-1 edges never commits.
- FRAME_DONE asserts one cycle after the completing commit, for exactly one cycle.
- Reset asserted mid-count or mid-frame returns everything to the reset values immediately. After reset release, the first pair needs a full STABLE_CYC count.
- Throughput: at most one commit per STABLE_CYC cycles.

## Test plan
- Scan digits 0..3 with patterns for 1, 2, 3, 4, each held 4 cycles, STABLE_CYC=4 -> DIGITS_OUT = 0x4321, DIG_VALID = 4'b1111, FRAME_DONE pulses once, one cycle after the digit-3 commit.
- Hold digit 2 with 0000100 and dp low for only 3 cycles, then switch -> no update. Hold it 4 cycles -> DIGITS_OUT[11:8] = 9, DP_OUT[2] = 0.
- Digit 1 with 1111111 held 10 cycles -> DIG_ERR[1] = 1, ERR_CNT = 1 (a single commit, not 7), DIGITS_OUT[7:4] unchanged.
- DIG_SEL = 4'b1010 or 4'b1111 with a valid pattern for 20 cycles -> no commit and no counter advance. The next legal pair needs 4 fresh cycles.
- 300 invalid commits -> ERR_CNT saturates at 255. Then CLR -> ERR_CNT, DIG_ERR and DIG_VALID = 0, DIGITS_OUT retained. CLR coincident with a commit -> no update.
- Assert RST_N low two cycles into a hold -> all outputs return to reset values asynchronously. After release, commit occurs only after 4 new stable cycles.
